// File: rtl/morse_pkg.sv
// Shared Morse symbol coding, FSM encoding and symbol-to-digit lookup.
// The encoder side reuses sym_to_digit to cross-check its own table.
package morse_pkg;

    localparam logic DOT  = 1'b1;
    localparam logic DASH = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StSpace,
        StDecode
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } digit_t;

    // sym is {s1, s2, s3, s4, s5}
    function automatic digit_t sym_to_digit(input logic [4:0] sym);
        digit_t res;
        res.valid = 1'b1;
        unique case (sym)
            5'b00000: res.digit = 4'd0;
            5'b10000: res.digit = 4'd1;
            5'b11000: res.digit = 4'd2;
            5'b11100: res.digit = 4'd3;
            5'b11110: res.digit = 4'd4;
            5'b11111: res.digit = 4'd5;
            5'b01111: res.digit = 4'd6;
            5'b00111: res.digit = 4'd7;
            5'b00011: res.digit = 4'd8;
            5'b00001: res.digit = 4'd9;
            default: begin
                res.valid = 1'b0;
                res.digit = 4'd0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for the asynchronous key line, cleared by the
// synchronous reset.
module sincronizador (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/decodificador_morse.sv
// Morse receiver for a single decimal digit: times marks and spaces on the
// synchronized key, collects five symbols and decodes them at the gap.
module decodificador_morse
    import morse_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MIN_PRESS  = 2,
    parameter int unsigned DASH_MIN   = 6,
    parameter int unsigned GAP_CYCLES = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic s4,
    output logic s5,
    output logic ready,
    output logic err
);

    logic ksync;

    sincronizador u_sincronizador (
        .clk  (clk),
        .reset(reset),
        .din  (key),
        .dout (ksync)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]       nsym_q, nsym_d;
    logic             ovf_q, ovf_d;
    logic [4:0]       sym_q, sym_d;
    logic [3:0]       digit_q, digit_d;
    logic [4:0]       sym_out_q, sym_out_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             symbol;
    logic             dec_go;
    logic             dec_ok;
    digit_t           lookup;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign symbol  = (cnt_q < CNT_W'(DASH_MIN)) ? DOT : DASH;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            nsym_q    <= '0;
            ovf_q     <= 1'b0;
            sym_q     <= '0;
            digit_q   <= '0;
            sym_out_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nsym_q    <= nsym_d;
            ovf_q     <= ovf_d;
            sym_q     <= sym_d;
            digit_q   <= digit_d;
            sym_out_q <= sym_out_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nsym_d  = nsym_q;
        ovf_d   = ovf_q;
        sym_d   = sym_q;
        unique case (state_q)
            StIdle: begin
                if (ksync) begin
                    state_d = StMark;
                    cnt_d   = CNT_W'(1);
                end
            end
            StMark: begin
                if (ksync) begin
                    cnt_d = cnt_inc;
                end else if (cnt_q < CNT_W'(MIN_PRESS)) begin
                    state_d = (nsym_q != 3'd0) ? StSpace : StIdle;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = StSpace;
                    cnt_d   = CNT_W'(1);
                    if (nsym_q < 3'd5) begin
                        for (int i = 0; i < 5; i++) begin
                            if (nsym_q == 3'(i)) sym_d[4-i] = symbol;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (nsym_q != 3'd6) nsym_d = nsym_q + 3'd1;
                end
            end
            StSpace: begin
                if (ksync) begin
                    state_d = StMark;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CNT_W'(GAP_CYCLES)) state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StIdle;
                cnt_d   = '0;
                nsym_d  = '0;
                ovf_d   = 1'b0;
                sym_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Results are registered on the edge entering DECODE so that ready/err
    // and the new a..d/s1..s5 all appear during the DECODE cycle.
    always_comb begin
        lookup    = sym_to_digit(sym_q);
        dec_go    = (state_q == StSpace) && (state_d == StDecode);
        dec_ok    = dec_go && !ovf_q && (nsym_q == 3'd5) && lookup.valid;
        ready_d   = dec_ok;
        err_d     = dec_go && !dec_ok;
        digit_d   = dec_ok ? lookup.digit : digit_q;
        sym_out_d = dec_ok ? sym_q : sym_out_q;
    end

    assign {a, b, c, d}           = digit_q;
    assign {s1, s2, s3, s4, s5}   = sym_out_q;
    assign ready                  = ready_q;
    assign err                    = err_q;

endmodule

// File: tb/tb_decodificador_morse.sv
// Directed self-checking bench for decodificador_morse: digit decode,
// latency, glitch rejection, invalid patterns, reset and counter saturation.
module tb_decodificador_morse;

    localparam int unsigned GAP = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key = 1'b0;
    logic a, b, c, d, s1, s2, s3, s4, s5, ready, err;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [3:0] got_q[$];

    decodificador_morse dut (
        .clk  (clk),
        .reset(reset),
        .key  (key),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .s1   (s1),
        .s2   (s2),
        .s3   (s3),
        .s4   (s4),
        .s5   (s5),
        .ready(ready),
        .err  (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ready) begin
            ready_cnt++;
            got_q.push_back({a, b, c, d});
        end
        if (err) err_cnt++;
        if (ready && err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mark(input int n);
        key = 1'b1;
        repeat (n) @(negedge clk);
        key = 1'b0;
    endtask

    task automatic space(input int n);
        key = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // pat[0] is the first symbol; 1 = dot (3 cycles), 0 = dash (8 cycles)
    task automatic send(input logic [5:0] pat, input int nsym);
        for (int i = 0; i < nsym; i++) begin
            mark(pat[i] ? 3 : 8);
            if (i != nsym - 1) space(3);
        end
    endtask

    // Hold key low until ready or err appears; n = cycles since key fell.
    task automatic run_gap(output int n, output logic saw_ready, output logic saw_err);
        n = -1;
        saw_ready = 1'b0;
        saw_err = 1'b0;
        key = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ready || err) begin
                n = i;
                saw_ready = ready;
                saw_err = err;
                break;
            end
        end
        space(3);
    endtask

    initial begin
        int n;
        logic rdy, er;
        int base_r, base_e, base_q;
        logic [4:0] codes[10];

        codes = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                  5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({a, b, c, d, s1, s2, s3, s4, s5, ready, err}), 32'h0);
        reset = 1'b0;
        space(2);

        // Digit 7 = dash dash dot dot dot; ready 2 sync cycles + GAP after key falls
        base_r = ready_cnt;
        send(6'b011100, 5);
        run_gap(n, rdy, er);
        check("d7_ready", 32'(rdy), 32'h1);
        check("d7_latency", 32'(n), 32'(GAP + 2));
        check("d7_abcd", 32'({a, b, c, d}), 32'h7);
        check("d7_sym", 32'({s1, s2, s3, s4, s5}), 32'b00111);
        space(10);
        check("d7_one_pulse", 32'(ready_cnt - base_r), 32'h1);
        check("d7_no_err", 32'(err_cnt), 32'h0);

        // All ten digits back to back with exactly GAP low cycles each
        base_r = ready_cnt;
        base_q = got_q.size();
        for (int i = 0; i < 10; i++) begin
            send({1'b0, codes[i]}, 5);
            space(GAP);
        end
        space(20);
        check("b2b_count", 32'(ready_cnt - base_r), 32'd10);
        check("b2b_no_err", 32'(err_cnt), 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (got_q.size() > base_q + i) check("b2b_digit", 32'(got_q[base_q+i]), 32'(i));
            else check("b2b_missing", 32'h0, 32'h1);
        end

        // Digit 3 with a one-cycle glitch between symbols
        mark(3); space(3); mark(3); space(1);
        mark(1); space(2);
        mark(3); space(3); mark(8); space(3); mark(8);
        run_gap(n, rdy, er);
        check("glitch_ready", 32'(rdy), 32'h1);
        check("glitch_abcd", 32'({a, b, c, d}), 32'h3);
        check("glitch_sym", 32'({s1, s2, s3, s4, s5}), 32'b11100);

        // Invalid characters leave outputs untouched
        base_r = ready_cnt;
        base_e = err_cnt;
        send(6'b010101, 5);
        run_gap(n, rdy, er);
        check("inv10101_err", 32'({rdy, er}), 32'b01);
        check("inv10101_hold", 32'({a, b, c, d, s1, s2, s3, s4, s5}), 32'({4'h3, 5'b11100}));
        send(6'b111111, 6);
        run_gap(n, rdy, er);
        check("six_dots_err", 32'({rdy, er}), 32'b01);
        send(6'b000111, 3);
        run_gap(n, rdy, er);
        check("three_dots_err", 32'({rdy, er}), 32'b01);
        check("inv_hold", 32'({a, b, c, d, s1, s2, s3, s4, s5}), 32'({4'h3, 5'b11100}));
        check("inv_err_count", 32'(err_cnt - base_e), 32'd3);
        check("inv_no_ready", 32'(ready_cnt - base_r), 32'h0);

        // Reset during the third mark
        mark(3); space(3); mark(8); space(3);
        key = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", 32'({a, b, c, d, s1, s2, s3, s4, s5, ready, err}), 32'h0);
        key = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        base_r = ready_cnt;
        base_e = err_cnt;
        space(30);
        check("rst_quiet", 32'({ready_cnt - base_r, err_cnt - base_e}), 32'h0);
        send(6'b011111, 5);
        run_gap(n, rdy, er);
        check("post_rst_ready", 32'(rdy), 32'h1);
        check("post_rst_abcd", 32'({a, b, c, d}), 32'h5);
        check("post_rst_sym", 32'({s1, s2, s3, s4, s5}), 32'b11111);

        // Saturating long mark still counts as a dash
        mark(300); space(3);
        send(6'b000000, 4);
        run_gap(n, rdy, er);
        check("long_ready", 32'({rdy, er}), 32'b10);
        check("long_abcd", 32'({a, b, c, d}), 32'h0);
        check("long_sym", 32'({s1, s2, s3, s4, s5}), 32'b00000);

        check("never_both", 32'(both_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
